// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the Clause 22 MDIO master.
package mdio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_TA,
    ST_DATA,
    ST_END
  } mdio_state_t;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;

  localparam int unsigned PHYAD_MSB = 10;
  localparam int unsigned PHYAD_LSB = 6;
  localparam int unsigned REGAD_MSB = 5;
  localparam int unsigned REGAD_LSB = 1;
  localparam int unsigned MODE_BIT  = 0;

  localparam logic [5:0] HDR_LAST  = 6'd13;
  localparam logic [5:0] TA_LAST   = 6'd1;
  localparam logic [5:0] DATA_LAST = 6'd15;

  // Everything after the preamble, MSB first; read frames carry zeros past
  // REGAD because the master releases the bus there anyway.
  function automatic logic [31:0] build_tx(input logic [10:0] am, input logic [15:0] d);
    logic wr;
    wr = am[MODE_BIT];
    return {MDIO_ST,
            wr ? MDIO_OP_WR : MDIO_OP_RD,
            am[PHYAD_MSB:PHYAD_LSB],
            am[REGAD_MSB:REGAD_LSB],
            wr ? 2'b10 : 2'b00,
            wr ? d : 16'h0000};
  endfunction

endpackage

// File: rtl/mdio_master_mdc_gen.sv
// MDC divider: low for CLK_DIV clk cycles then high for CLK_DIV, with drive/sample/bit-end strobes.
module mdio_mdc_gen #(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic fall_tick,
  output logic rise_tick,
  output logic bit_end
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign mdc       = phase;
  assign fall_tick = en && !phase && (cnt == '0);
  assign rise_tick = en && !phase && (cnt == LAST);
  assign bit_end   = en &&  phase && (cnt == LAST);

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO master: one read or write management frame per start edge.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 5,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [10:0] addr_mode_i,
  input  logic [15:0] data_i,
  input  logic        pre_sup_i,
  output logic        MDC_o,
  inout  wire         MDIO_io,
  output logic [15:0] data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        ta_err_o
);

  mdio_state_t state, state_next;

  logic [5:0]  bit_cnt;
  logic [5:0]  cnt_val;
  logic        cnt_load;
  logic        launch;
  logic        start_q;
  logic        mode_wr;
  logic [31:0] tx_sh;
  logic [15:0] rx_sh;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in;
  logic        oe_cur;
  logic        fall_tick;
  logic        rise_tick;
  logic        bit_end;
  logic        last_bit;

  mdio_mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (busy_o),
    .mdc       (MDC_o),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick),
    .bit_end   (bit_end)
  );

  assign MDIO_io  = mdio_oe ? mdio_out : 1'bz;
  assign mdio_in  = MDIO_io;
  assign last_bit = bit_end && (bit_cnt == '0);

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    oe_cur     = 1'b0;
    launch     = (state == ST_IDLE) && start_i && !start_q;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          cnt_load = 1'b1;
          if (pre_sup_i) begin
            state_next = ST_HDR;
            cnt_val    = HDR_LAST;
          end else begin
            state_next = ST_PRE;
            cnt_val    = 6'(PREAMBLE_LEN - 1);
          end
        end
      end
      ST_PRE: begin
        oe_cur = 1'b1;
        if (last_bit) begin
          state_next = ST_HDR;
          cnt_load   = 1'b1;
          cnt_val    = HDR_LAST;
        end
      end
      ST_HDR: begin
        oe_cur = 1'b1;
        if (last_bit) begin
          state_next = ST_TA;
          cnt_load   = 1'b1;
          cnt_val    = TA_LAST;
        end
      end
      ST_TA: begin
        oe_cur = mode_wr;
        if (last_bit) begin
          state_next = ST_DATA;
          cnt_load   = 1'b1;
          cnt_val    = DATA_LAST;
        end
      end
      ST_DATA: begin
        oe_cur = mode_wr;
        if (last_bit) begin
          state_next = ST_END;
          cnt_load   = 1'b1;
          cnt_val    = '0;
        end
      end
      ST_END: begin
        if (bit_end) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      start_q  <= 1'b0;
      mode_wr  <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      mdio_out <= 1'b0;
      mdio_oe  <= 1'b0;
      data_o   <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      ta_err_o <= 1'b0;
    end else begin
      state   <= state_next;
      start_q <= start_i;
      done_o  <= 1'b0;

      if (cnt_load)
        bit_cnt <= cnt_val;
      else if (bit_end && bit_cnt != '0)
        bit_cnt <= bit_cnt - 6'd1;

      if (launch) begin
        tx_sh    <= build_tx(addr_mode_i, data_i);
        mode_wr  <= addr_mode_i[MODE_BIT];
        ta_err_o <= 1'b0;
        busy_o   <= 1'b1;
      end

      // The PRE bits come from a constant; the shift register only starts at ST.
      if (fall_tick) begin
        mdio_oe <= oe_cur;
        if (state == ST_PRE) begin
          mdio_out <= 1'b1;
        end else if (state == ST_HDR || state == ST_TA || state == ST_DATA) begin
          mdio_out <= tx_sh[31];
          tx_sh    <= {tx_sh[30:0], 1'b0};
        end
      end

      if (rise_tick && !mode_wr) begin
        if (state == ST_TA && bit_cnt == '0) ta_err_o <= mdio_in;
        if (state == ST_DATA) rx_sh <= {rx_sh[14:0], mdio_in};
      end

      if (state == ST_END && bit_end) begin
        busy_o  <= 1'b0;
        done_o  <= 1'b1;
        mdio_oe <= 1'b0;
        if (!mode_wr) data_o <= rx_sh;
      end
    end
  end

endmodule
